keypad_bcd_entry: RTL and testbench
===================================

# keypad_bcd_entry

Matrix-keypad input front end for the keyboard adder: scans a 4x4 active-low keypad and debounces key presses. Accepted keys are assembled into an 8-digit BCD entry word. Its data_BCD output feeds the multiplexed seven-segment display driver directly, so the display shows digits as the user types them. The nibble code 4'b1010 is the display's '-' glyph and is insertable from the keypad.

## Interface
- SCAN_DIV, default 131233: clk cycles spent driving each row; must be at least 4.
- DEBOUNCE_SCANS, default 4: consecutive identical full-scan frames required to accept a press or a release; range 1..15.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- row_out  out  4  row drive, active-low, one-hot zero.
- col_in  in  4  column sense, active-low; the board pulls these up.
- key_valid  out  1  one-cycle pulse for each accepted press.
- key_code  out  4  code of the last accepted key; holds its value between presses.
- data_BCD  out  32  entry buffer; nibble 0 is the rightmost display digit.
- digit_count  out  4  number of entered digits, 0..8.
- overflow  out  1  sticky flag: an entry was attempted while the buffer was full.

## Operation
- **Key map** (row r, column c; codes in hex):
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E, 0, F, D
- **Scan**
  - Row index r runs 0..3. row_out = ~(4'b0001 << r).
  - A divider counts 0..SCAN_DIV-1. On its terminal count, sample the synchronized col_in and advance r, wrapping 3 to 0.
  - col_in passes through a 2-flop synchronizer before it is used.
  - A frame ends at the row-3 sample.
  - Frame result is SINGLE(code) if exactly one key was seen across all 4 rows, otherwise NONE. Zero keys and two or more keys (ghosting) both give NONE.
- **Debounce FSM.** States IDLE, PRESS_CHK, HELD, REL_CHK, with a frame counter cnt. The FSM evaluates once per frame end.
  - IDLE:
    - SINGLE(k): cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately; otherwise go to PRESS_CHK.
  - PRESS_CHK:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - Any other result: go to IDLE.
  - HELD:
    - NONE: cnt=1 and go to REL_CHK. If DEBOUNCE_SCANS==1, go straight to IDLE.
    - Otherwise stay. There is no auto-repeat.
  - REL_CHK:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - SINGLE: go back to HELD.
- **Accept** pulses key_valid, sets key_code=cand, and applies the action for cand:
  - 0..9 or A: if digit_count<8, shift in: data_BCD={data_BCD[27:0],cand}, digit_count+1. Else leave the buffer and count unchanged and set overflow=1.
  - B (backspace): if digit_count>0, data_BCD={4'h0,data_BCD[31:4]}, digit_count-1. Else no change. overflow is unaffected.
  - C (clear): data_BCD=0, digit_count=0, overflow=0.
  - D, E, F: key_valid and key_code update only; the buffer is unchanged.

## Timing
- **Reset values:**
  - row_out=4'b1110, r=0, divider=0
  - state=IDLE, cnt=0
  - key_valid=0, key_code=0, data_BCD=0, digit_count=0, overflow=0
- **Reset mid-operation:** asserting rst aborts any debounce or frame in progress immediately; outputs return to reset values with no clock needed.
- **Sample point:** col_in is sampled on the last cycle of each row period, which gives SCAN_DIV-1 cycles of settling.
- **Synchronizer latency:** 2 clk.
- **Frame period:** 4*SCAN_DIV clk.
- **Accept latency:** key_valid rises on the clk edge after the DEBOUNCE_SCANS-th consistent frame end. data_BCD, digit_count, key_code and overflow update on that same edge. key_valid is high for exactly one cycle.
- **Minimum press interval:** press to release to next press is at least 2*DEBOUNCE_SCANS frames.
- **Key change while held:** changing directly from one key to another without a release frame produces no new accept.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2. The keypad model pulls col_in[c] low while row_out[r] is 0 and key (r,c) is pressed.
- **Reset:** assert rst mid-scan → all outputs reach reset values asynchronously; row_out=1110.
- **Entry:** press and release 1, 2, 3 → three key_valid pulses; data_BCD=32'h0000_0123, digit_count=3.
- **Overflow:** enter 9 digits 1..9 → data_BCD=32'h1234_5678, digit_count=8, overflow=1. Then press C → data_BCD=0, digit_count=0, overflow=0.
- **Backspace:** after entering 4, 5, A, press B → data_BCD=32'h0000_0045, digit_count=2. With digit_count=0, press B → no buffer change, key_valid still pulses.
- **Debounce:** toggle key 7 every frame → no key_valid. Hold key 7 for 10 frames → exactly one pulse. Press 1 and 2 together → no pulse.
- **Release bounce:** hold 5, release for 1 frame, press for 1 frame, then release → a single key_valid in total.

Source files
------------

// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry: 4x4 keypad scanner, debouncer and 8-digit BCD entry buffer
module keypad_bcd_entry #(
    parameter int SCAN_DIV       = 131233,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] data_BCD,
    output logic [3:0]  digit_count,
    output logic        overflow
);
    localparam int          DW   = $clog2(SCAN_DIV);
    localparam logic [3:0]  DS   = 4'(DEBOUNCE_SCANS);
    localparam logic [63:0] KMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [DW-1:0] div_q;
    logic [1:0]    row_q;
    logic [1:0]    hits_q;
    logic [3:0]    fcode_q;
    logic [3:0]    cnt_q, cnt_d, cand_q, cand_d, cnt_inc;
    logic          kv_q, ovf_q, accept;
    logic [3:0]    code_q, dcnt_q;
    logic [31:0]   bcd_q;
    logic [2:0]    row_n, tot;
    logic [1:0]    col;
    logic [3:0]    row_code, f_code;
    logic          tc, frame_end, single, none;

    assign row_out     = ~(4'b0001 << row_q);
    assign key_valid   = kv_q;
    assign key_code    = code_q;
    assign data_BCD    = bcd_q;
    assign digit_count = dcnt_q;
    assign overflow    = ovf_q;

    assign tc        = div_q == DW'(SCAN_DIV - 1);
    assign frame_end = tc && row_q == 2'd3;
    assign tot       = {1'b0, hits_q} + row_n;
    assign row_code  = KMAP[{row_q, col, 2'b00} +: 4];
    assign f_code    = hits_q == 2'd1 ? fcode_q : row_code;
    assign single    = frame_end && tot == 3'd1;
    assign none      = frame_end && tot != 3'd1;
    assign cnt_inc   = cnt_q + 4'd1;

    // Count pressed columns in the current row and remember which one
    always_comb begin
        row_n = '0;
        col   = '0;
        for (int c = 0; c < 4; c++)
            if (!sync2_q[c]) begin
                row_n = row_n + 3'd1;
                col   = 2'(c);
            end
    end

    // Column synchronizer, row divider and per-frame key accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            div_q   <= '0;
            row_q   <= '0;
            hits_q  <= '0;
            fcode_q <= '0;
        end else begin
            sync1_q <= col_in;
            sync2_q <= sync1_q;
            div_q   <= tc ? '0 : div_q + 1'b1;
            if (tc) begin
                row_q   <= row_q + 2'd1;
                hits_q  <= frame_end ? 2'd0 : (tot > 3'd2 ? 2'd2 : tot[1:0]);
                fcode_q <= row_n == 3'd1 ? row_code : fcode_q;
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Debounce next state, evaluated once per frame end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (frame_end)
            case (state_q)
                IDLE:
                    if (single) begin
                        cand_d  = f_code;
                        cnt_d   = 4'd1;
                        accept  = DS == 4'd1;
                        state_d = DS == 4'd1 ? HELD : PRESS_CHK;
                    end
                PRESS_CHK:
                    if (single && f_code == cand_q) begin
                        cnt_d   = cnt_inc;
                        accept  = cnt_inc == DS;
                        state_d = cnt_inc == DS ? HELD : PRESS_CHK;
                    end else
                        state_d = IDLE;
                HELD:
                    if (none) begin
                        cnt_d   = 4'd1;
                        state_d = DS == 4'd1 ? IDLE : REL_CHK;
                    end
                default:
                    if (none) begin
                        cnt_d   = cnt_inc;
                        state_d = cnt_inc == DS ? IDLE : REL_CHK;
                    end else
                        state_d = HELD;
            endcase
    end

    // Apply the accepted key to the entry buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kv_q   <= 1'b0;
            code_q <= '0;
            bcd_q  <= '0;
            dcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            kv_q <= accept;
            if (accept) begin
                code_q <= cand_d;
                if (cand_d <= 4'hA) begin
                    if (dcnt_q < 4'd8) begin
                        bcd_q  <= {bcd_q[27:0], cand_d};
                        dcnt_q <= dcnt_q + 4'd1;
                    end else
                        ovf_q <= 1'b1;
                end else if (cand_d == 4'hB) begin
                    if (dcnt_q != 4'd0) begin
                        bcd_q  <= {4'h0, bcd_q[31:4]};
                        dcnt_q <= dcnt_q - 4'd1;
                    end
                end else if (cand_d == 4'hC) begin
                    bcd_q  <= '0;
                    dcnt_q <= '0;
                    ovf_q  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb_keypad_bcd_entry: table-driven check of keypad scan, debounce and BCD entry
module tb_keypad_bcd_entry;
    localparam int SD = 4;
    localparam int DS = 2;
    localparam int FR = 4 * SD;

    localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, K3 = 16'h0004, KA = 16'h0008;
    localparam logic [15:0] K4 = 16'h0010, K5 = 16'h0020, K6 = 16'h0040, KB = 16'h0080;
    localparam logic [15:0] K7 = 16'h0100, K8 = 16'h0200, K9 = 16'h0400, KC = 16'h0800;
    localparam logic [15:0] KE = 16'h1000, K0 = 16'h2000, KF = 16'h4000, KD = 16'h8000;

    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          rel;
        int          pulses;
        logic [31:0] bcd;
        logic [3:0]  cnt;
        logic        ovf;
        logic [3:0]  code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_out, col_in, key_code, digit_count;
    logic        key_valid, overflow;
    logic [31:0] data_BCD;
    logic [15:0] keys = '0;
    int          checks = 0, failures = 0, pulses = 0, wide = 0, p0;
    logic        kv_prev = 1'b0;
    vec_t        v[23];

    keypad_bcd_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in),
        .key_valid(key_valid), .key_code(key_code), .data_BCD(data_BCD),
        .digit_count(digit_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its column to its driven-low row
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    // Count key_valid pulses and flag any pulse wider than one cycle
    always @(negedge clk) begin
        if (key_valid) begin
            pulses++;
            if (kv_prev) wide++;
        end
        kv_prev = key_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * FR) @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic [31:0] bcd, input logic [3:0] cnt,
                             input logic ovf, input logic [3:0] code);
        chk({tag, "_bcd"}, data_BCD, bcd);
        chk({tag, "_cnt"}, 32'(digit_count), 32'(cnt));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        chk({tag, "_code"}, 32'(key_code), 32'(code));
    endtask

    initial begin
        v[0]  = '{K1, 4, 4, 1, 32'h0000_0001, 4'd1, 1'b0, 4'h1};
        v[1]  = '{K2, 4, 4, 1, 32'h0000_0012, 4'd2, 1'b0, 4'h2};
        v[2]  = '{K3, 4, 4, 1, 32'h0000_0123, 4'd3, 1'b0, 4'h3};
        v[3]  = '{K4, 4, 4, 1, 32'h0000_1234, 4'd4, 1'b0, 4'h4};
        v[4]  = '{K5, 4, 4, 1, 32'h0001_2345, 4'd5, 1'b0, 4'h5};
        v[5]  = '{K6, 4, 4, 1, 32'h0012_3456, 4'd6, 1'b0, 4'h6};
        v[6]  = '{K7, 4, 4, 1, 32'h0123_4567, 4'd7, 1'b0, 4'h7};
        v[7]  = '{K8, 4, 4, 1, 32'h1234_5678, 4'd8, 1'b0, 4'h8};
        v[8]  = '{K9, 4, 4, 1, 32'h1234_5678, 4'd8, 1'b1, 4'h9};
        v[9]  = '{KC, 4, 4, 1, 32'h0000_0000, 4'd0, 1'b0, 4'hC};
        v[10] = '{K4, 4, 4, 1, 32'h0000_0004, 4'd1, 1'b0, 4'h4};
        v[11] = '{K5, 4, 4, 1, 32'h0000_0045, 4'd2, 1'b0, 4'h5};
        v[12] = '{KA, 4, 4, 1, 32'h0000_045A, 4'd3, 1'b0, 4'hA};
        v[13] = '{KB, 4, 4, 1, 32'h0000_0045, 4'd2, 1'b0, 4'hB};
        v[14] = '{KB, 4, 4, 1, 32'h0000_0004, 4'd1, 1'b0, 4'hB};
        v[15] = '{KB, 4, 4, 1, 32'h0000_0000, 4'd0, 1'b0, 4'hB};
        v[16] = '{KB, 4, 4, 1, 32'h0000_0000, 4'd0, 1'b0, 4'hB};
        v[17] = '{KD, 4, 4, 1, 32'h0000_0000, 4'd0, 1'b0, 4'hD};
        v[18] = '{K0, 4, 4, 1, 32'h0000_0000, 4'd1, 1'b0, 4'h0};
        v[19] = '{K1 | K2, 4, 4, 0, 32'h0000_0000, 4'd1, 1'b0, 4'h0};
        v[20] = '{K7, 10, 4, 1, 32'h0000_0007, 4'd2, 1'b0, 4'h7};
        v[21] = '{KE, 4, 4, 1, 32'h0000_0007, 4'd2, 1'b0, 4'hE};
        v[22] = '{KF, 4, 4, 1, 32'h0000_0007, 4'd2, 1'b0, 4'hF};

        #1;
        chk("rst_row", 32'(row_out), 32'hE);
        chk("rst_kv", 32'(key_valid), 32'h0);
        chk_state("rst", 32'h0, 4'd0, 1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("scan_row0", 32'(row_out), 32'hE);
        @(negedge clk);
        chk("scan_row1", 32'(row_out), 32'hD);

        for (int i = 0; i < 23; i++) begin
            p0 = pulses;
            keys = v[i].keys;
            frames(v[i].hold);
            keys = '0;
            frames(v[i].rel);
            chk($sformatf("v%0d_pulses", i), 32'(pulses - p0), 32'(v[i].pulses));
            chk_state($sformatf("v%0d", i), v[i].bcd, v[i].cnt, v[i].ovf, v[i].code);
        end

        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? K7 : 16'h0;
            frames(1);
        end
        keys = '0;
        frames(4);
        chk("toggle_pulses", 32'(pulses - p0), 32'd0);
        chk_state("toggle", 32'h0000_0007, 4'd2, 1'b0, 4'hF);

        p0 = pulses;
        keys = K5;
        frames(4);
        keys = '0;
        frames(1);
        keys = K5;
        frames(1);
        keys = '0;
        frames(4);
        chk("bounce_pulses", 32'(pulses - p0), 32'd1);
        chk_state("bounce", 32'h0000_0075, 4'd3, 1'b0, 4'h5);

        keys = K9;
        frames(1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_row", 32'(row_out), 32'hE);
        chk("mid_kv", 32'(key_valid), 32'h0);
        chk_state("mid", 32'h0, 4'd0, 1'b0, 4'h0);
        keys = '0;
        #10 rst = 1'b0;
        frames(4);
        chk("post_rst_bcd", data_BCD, 32'h0);
        chk("kv_width", 32'(wide), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
